// File: rtl/izh_fixed_pkg.sv
// Shared definitions for the Izhikevich recovery-variable update sequencer.
//   n_def / q_def : default word width and fractional bits (Q16.16)
//   NEG_ONE       : sign-magnitude -1.0 at the default format
//   state_t       : sequencer states, one per cycle of the update schedule
package izh_fixed_pkg;

   localparam int N_DEF = 32;
   localparam int Q_DEF = 16;

   localparam logic [N_DEF-1:0] NEG_ONE = {1'b1, 31'(32'h0001_0000)};

   typedef enum logic [3:0] {
      IDLE,
      BV,
      NW,
      SUM,
      AT,
      DTT,
      DW,
      ACC,
      SPK,
      DONE
   } state_t;

endpackage

// File: rtl/ops.sv
// Sign-magnitude fixed-point arithmetic primitives.
//   mult : y = a * b, magnitude product shifted right by q and truncated
//          to n-1 bits, sign = sign(a) xor sign(b)
//   add  : y = a + b in sign-magnitude; equal signs add magnitudes (wrapping
//          on overflow), unequal signs subtract the smaller magnitude from
//          the larger and keep the larger operand's sign (a wins on a tie)
// Ports (both): a, b inputs [n-1:0]; y output [n-1:0]
module mult #(
   parameter int N = 32,
   parameter int Q = 16
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] y
);

   logic [2*N-3:0] prod;
   logic           unused_prod_bits;

   // Full-precision magnitude product; only the window starting at bit q
   // survives, the fraction below and the overflow above are dropped.
   always_comb begin
      prod = {{(N-1){1'b0}}, a[N-2:0]} * {{(N-1){1'b0}}, b[N-2:0]};
      y    = {a[N-1] ^ b[N-1], prod[Q +: N-1]};
   end

   assign unused_prod_bits = ^prod;

endmodule

module add #(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] y
);

   logic [N-2:0] mag_a;
   logic [N-2:0] mag_b;

   // Magnitude add or subtract depending on whether the signs agree; the
   // result sign follows the larger magnitude so no two's-complement step
   // is needed.
   always_comb begin
      mag_a = a[N-2:0];
      mag_b = b[N-2:0];
      y     = '0;
      if (a[N-1] == b[N-1]) begin
         y = {a[N-1], mag_a + mag_b};
      end else if (mag_a >= mag_b) begin
         y = {a[N-1], mag_a - mag_b};
      end else begin
         y = {b[N-1], mag_b - mag_a};
      end
   end

endmodule

// File: rtl/izh_w_update_seq.sv
// Multi-cycle sequencer for the Izhikevich recovery-variable update:
//   dw = (a*((b*v) + (-1*w))) * (dt*t);   w_next = w + dw (+ d on spike)
// One mult and one add are time-shared across all terms, one term per cycle.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start_i, spike_i    update request (sampled in IDLE) and spike flag
//   a_i, b_i, d_i       model parameters
//   v_i, w_i            membrane and recovery values
//   dt_i, t_i           step size and time operand
//   busy_o              high whenever not IDLE
//   done_o              one-cycle pulse, dw_o/w_o valid in that cycle
//   dw_o, w_o           last computed dw and updated w, held between updates
module izh_w_update_seq
   import izh_fixed_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int Q = Q_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start_i,
   input  logic         spike_i,
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic [N-1:0] d_i,
   input  logic [N-1:0] v_i,
   input  logic [N-1:0] w_i,
   input  logic [N-1:0] dt_i,
   input  logic [N-1:0] t_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [N-1:0] dw_o,
   output logic [N-1:0] w_o
);

   // Sign-magnitude -1.0 at the configured width and fraction.
   localparam logic [N-2:0] ONE_MAG     = (N-1)'(1) << Q;
   localparam logic [N-1:0] NEG_ONE_LOC = {1'b1, ONE_MAG};

   state_t state;
   state_t state_next;

   logic [N-1:0] a_q, b_q, d_q, v_q, w_q, dt_q, t_q;
   logic         spike_q;
   logic [N-1:0] t1, t2, t3, t4, t5, dw_q, wn_q;

   logic [N-1:0] mul_a, mul_b, mul_y;
   logic [N-1:0] add_a, add_b, add_y;

   mult #(.N(N), .Q(Q)) u_mult (
      .a(mul_a),
      .b(mul_b),
      .y(mul_y)
   );

   add #(.N(N)) u_add (
      .a(add_a),
      .b(add_b),
      .y(add_y)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. start_i only matters in IDLE, so a request during
   // an update (including the DONE cycle) is dropped rather than queued.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start_i) state_next = BV;
         BV:      state_next = NW;
         NW:      state_next = SUM;
         SUM:     state_next = AT;
         AT:      state_next = DTT;
         DTT:     state_next = DW;
         DW:      state_next = ACC;
         ACC:     state_next = spike_q ? SPK : DONE;
         SPK:     state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Operand steering into the shared units depends on state alone, so
   // the unit inputs never see a combinational path from the ports.
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      add_a = '0;
      add_b = '0;
      case (state)
         BV:  begin mul_a = b_q;         mul_b = v_q;  end
         NW:  begin mul_a = NEG_ONE_LOC; mul_b = w_q;  end
         SUM: begin add_a = t1;          add_b = t2;   end
         AT:  begin mul_a = a_q;         mul_b = t3;   end
         DTT: begin mul_a = dt_q;        mul_b = t_q;  end
         DW:  begin mul_a = t4;          mul_b = t5;   end
         ACC: begin add_a = w_q;         add_b = dw_q; end
         SPK: begin add_a = wn_q;        add_b = d_q;  end
         default: ;
      endcase
   end

   // Operand capture, scratch registers and result registers. Results are
   // loaded on the edge that enters DONE (from ACC without a spike, or from
   // SPK) so dw_o/w_o are already valid while done_o is high.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         d_q     <= '0;
         v_q     <= '0;
         w_q     <= '0;
         dt_q    <= '0;
         t_q     <= '0;
         spike_q <= 1'b0;
         t1      <= '0;
         t2      <= '0;
         t3      <= '0;
         t4      <= '0;
         t5      <= '0;
         dw_q    <= '0;
         wn_q    <= '0;
         dw_o    <= '0;
         w_o     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  a_q     <= a_i;
                  b_q     <= b_i;
                  d_q     <= d_i;
                  v_q     <= v_i;
                  w_q     <= w_i;
                  dt_q    <= dt_i;
                  t_q     <= t_i;
                  spike_q <= spike_i;
               end
            end
            BV:  t1   <= mul_y;
            NW:  t2   <= mul_y;
            SUM: t3   <= add_y;
            AT:  t4   <= mul_y;
            DTT: t5   <= mul_y;
            DW:  dw_q <= mul_y;
            ACC: begin
               wn_q <= add_y;
               if (!spike_q) begin
                  dw_o <= dw_q;
                  w_o  <= add_y;
               end
            end
            SPK: begin
               wn_q <= add_y;
               dw_o <= dw_q;
               w_o  <= add_y;
            end
            default: ;
         endcase
      end
   end

   assign busy_o = (state != IDLE);
   assign done_o = (state == DONE);

endmodule
